// File: rtl/line_sequencer.sv
// Frame sequencer: optional black clear sweep, then one drawer launch per ROM line.
// Muxes the framebuffer write port between the clear sweep and the drawer stream.
module line_sequencer #(
  parameter int NUM_LINES = 37,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int COORD_W   = 11,
  parameter int ADDR_W    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               clear_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COORD_W-1:0] rom_x0,
  input  logic [COORD_W-1:0] rom_y0,
  input  logic [COORD_W-1:0] rom_x1,
  input  logic [COORD_W-1:0] rom_y1,
  output logic [COORD_W-1:0] ld_x0,
  output logic [COORD_W-1:0] ld_y0,
  output logic [COORD_W-1:0] ld_x1,
  output logic [COORD_W-1:0] ld_y1,
  output logic               ld_start,
  input  logic [COORD_W-1:0] ld_x,
  input  logic [COORD_W-1:0] ld_y,
  input  logic               ld_done,
  output logic [COORD_W-1:0] fb_x,
  output logic [COORD_W-1:0] fb_y,
  output logic               fb_color,
  output logic               fb_write,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [COORD_W-1:0] LP_XMAX = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] LP_YMAX = COORD_W'(SCREEN_H - 1);
  localparam logic [ADDR_W-1:0]  LP_AMAX = ADDR_W'(NUM_LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_LAUNCH,
    S_GUARD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [COORD_W-1:0] r_cx;
  logic [COORD_W-1:0] r_cy;
  logic [COORD_W-1:0] r_hx;
  logic [COORD_W-1:0] r_hy;
  logic [ADDR_W-1:0]  r_addr;
  logic [COORD_W-1:0] r_x0;
  logic [COORD_W-1:0] r_y0;
  logic [COORD_W-1:0] r_x1;
  logic [COORD_W-1:0] r_y1;
  logic               r_ld_start;
  logic               r_frame_done;

  logic [COORD_W-1:0] w_fb_x;
  logic [COORD_W-1:0] w_fb_y;

  // Frame FSM; r_hx/r_hy remember the last written pixel for idle states
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cx         <= '0;
      r_cy         <= '0;
      r_hx         <= '0;
      r_hy         <= '0;
      r_addr       <= '0;
      r_x0         <= '0;
      r_y0         <= '0;
      r_x1         <= '0;
      r_y1         <= '0;
      r_ld_start   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (clear_en) begin
              r_cx    <= '0;
              r_cy    <= '0;
              r_state <= S_CLEAR;
            end else begin
              r_addr  <= '0;
              r_state <= S_FETCH;
            end
          end
        end
        S_CLEAR: begin
          r_hx <= r_cx;
          r_hy <= r_cy;
          if (r_cx == LP_XMAX) begin
            r_cx <= '0;
            if (r_cy == LP_YMAX) begin
              r_cy    <= '0;
              r_addr  <= '0;
              r_state <= S_FETCH;
            end else begin
              r_cy <= r_cy + 1'b1;
            end
          end else begin
            r_cx <= r_cx + 1'b1;
          end
        end
        S_FETCH: begin
          r_x0       <= rom_x0;
          r_y0       <= rom_y0;
          r_x1       <= rom_x1;
          r_y1       <= rom_y1;
          r_ld_start <= 1'b1;
          r_state    <= S_LAUNCH;
        end
        S_LAUNCH: begin
          r_ld_start <= 1'b0;
          r_state    <= S_GUARD;
        end
        S_GUARD: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_hx <= ld_x;
          r_hy <= ld_y;
          if (ld_done) begin
            if (r_addr == LP_AMAX) begin
              r_frame_done <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_frame_done <= 1'b0;
          r_addr       <= '0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Framebuffer address mux: sweep counter, drawer pixel, or held value
  always_comb begin
    w_fb_x = r_hx;
    w_fb_y = r_hy;
    if (r_state == S_CLEAR) begin
      w_fb_x = r_cx;
      w_fb_y = r_cy;
    end else if (r_state == S_WAIT) begin
      w_fb_x = ld_x;
      w_fb_y = ld_y;
    end
  end

  assign fb_x       = w_fb_x;
  assign fb_y       = w_fb_y;
  assign fb_write   = (r_state == S_CLEAR) || (r_state == S_WAIT);
  assign fb_color   = (r_state == S_WAIT);
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;
  assign rom_addr   = r_addr;
  assign ld_x0      = r_x0;
  assign ld_y0      = r_y0;
  assign ld_x1      = r_x1;
  assign ld_y1      = r_y1;
  assign ld_start   = r_ld_start;

endmodule
